pwm_audio_sink: RTL and testbench

- Consumer end of the 16-bit audio valid/ready stream: the block that drives ready back to the sample source.
- Accepts signed PCM samples into a one-entry buffer and converts each to a PWM duty.
- Applies one sample per frame (REPEAT PWM periods) and drives a single-bit PWM pin to the speaker filter.
- Soft start/stop: ramps duty 0 -> midscale on enable, and midscale-or-current -> 0 on disable, to suppress pops.

---
 rtl/pwm_audio_sink_if.sv | 20 ++
 rtl/pwm_audio_sink.sv | 160 ++++++++++++++++
 tb/tb_pwm_audio_sink.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_audio_sink_if.sv
// Audio sample stream: 16-bit signed PCM with a valid/ready handshake.
interface pwm_audio_sink_if;
    logic [15:0] audio_in;
    logic        audio_in_valid;
    logic        audio_in_rdy;

    // Sample source side
    modport master (
        output audio_in,
        output audio_in_valid,
        input  audio_in_rdy
    );

    // Sample sink side (the PWM player)
    modport slave (
        input  audio_in,
        input  audio_in_valid,
        output audio_in_rdy
    );
endinterface

// File: rtl/pwm_audio_sink.sv
// PWM audio sink: one-entry sample buffer, one sample per frame of REPEAT PWM
// periods, with soft duty ramps on enable/disable to avoid speaker pops.
module pwm_audio_sink #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned REPEAT   = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    pwm_audio_sink_if.slave audio,
    output logic            pwm_out,
    output logic            underrun,
    output logic            active
);

    localparam int unsigned REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX      = '1;
    localparam logic [PWM_BITS-1:0] DUTY_MID     = PWM_BITS'(2 ** (PWM_BITS - 1));
    localparam logic [PWM_BITS-1:0] DUTY_PRE_MID = PWM_BITS'(2 ** (PWM_BITS - 1) - 1);
    localparam logic [REP_W-1:0]    REP_LAST     = REP_W'(REPEAT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PWM_BITS-1:0] r_cnt;
    logic [REP_W-1:0]    r_rep;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_duty_next;
    logic [PWM_BITS-1:0] r_buf;
    logic [PWM_BITS-1:0] w_buf_next;
    logic                r_buf_full;
    logic                w_buf_full_next;
    logic                r_pwm;
    logic                r_underrun;
    logic                w_underrun_next;
    logic                r_active;

    logic                w_wrap;
    logic                w_frame;
    logic                w_rdy;
    logic                w_xfer;
    logic [PWM_BITS-1:0] w_conv;

    assign w_wrap  = (r_cnt == CNT_MAX);
    assign w_frame = w_wrap && (r_rep == REP_LAST);
    assign w_rdy   = (r_state == RUN) && !r_buf_full;
    assign w_xfer  = audio.audio_in_valid && w_rdy;
    // Top bits of the signed sample with the sign flipped -> offset-binary duty
    assign w_conv  = audio.audio_in[15 -: PWM_BITS] ^ DUTY_MID;

    assign audio.audio_in_rdy = w_rdy;
    assign pwm_out            = r_pwm;
    assign underrun           = r_underrun;
    assign active             = r_active;

    // Free-running PWM period counter and period-within-frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_rep <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_wrap) begin
                r_rep <= (r_rep == REP_LAST) ? '0 : r_rep + 1'b1;
            end
        end
    end

    // State, duty, sample buffer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_duty     <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_pwm      <= 1'b0;
            r_underrun <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_duty     <= w_duty_next;
            r_buf      <= w_buf_next;
            r_buf_full <= w_buf_full_next;
            r_pwm      <= (r_cnt < r_duty);
            r_underrun <= w_underrun_next;
            r_active   <= (w_state_next != IDLE);
        end
    end

    // Next-state logic: ramps step on period wraps, samples load on frames
    always_comb begin
        w_state_next    = r_state;
        w_duty_next     = r_duty;
        w_buf_next      = r_buf;
        w_buf_full_next = r_buf_full;
        w_underrun_next = 1'b0;

        if (w_xfer) begin
            w_buf_next      = w_conv;
            w_buf_full_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_duty_next = '0;
                if (enable) begin
                    w_state_next = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (!enable) begin
                    w_state_next = RAMP_DOWN;
                end else if (w_wrap) begin
                    // Re-entry from a ramp-down that started above midscale: just resume
                    if (r_duty >= DUTY_MID) begin
                        w_state_next = RUN;
                    end else begin
                        w_duty_next = r_duty + 1'b1;
                        if (r_duty == DUTY_PRE_MID) begin
                            w_state_next = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (!enable) begin
                    w_state_next    = RAMP_DOWN;
                    w_buf_full_next = 1'b0;
                end else if (w_frame) begin
                    // A full buffer forces rdy low, so this never races a transfer
                    if (r_buf_full) begin
                        w_duty_next     = r_buf;
                        w_buf_full_next = 1'b0;
                    end else begin
                        w_underrun_next = 1'b1;
                    end
                end
            end
            RAMP_DOWN: begin
                if (enable) begin
                    w_state_next = RAMP_UP;
                end else if (r_duty == '0) begin
                    w_state_next = IDLE;
                end else if (w_wrap) begin
                    w_duty_next = r_duty - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_audio_sink.sv
// Directed bench for pwm_audio_sink at PWM_BITS=4, REPEAT=2 (16-clk period, 32-clk frame).
module tb_pwm_audio_sink;

    localparam int PWM_BITS = 4;
    localparam int REPEAT   = 2;
    localparam int PER      = 16;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b0;
    logic pwm_out;
    logic underrun;
    logic active;

    int checks   = 0;
    int failures = 0;

    int n = 0;
    int un_cnt = 0;
    int un_n = -1;
    int rdy_hi = 0;
    int first_rdy = -1;
    int act_fall = -1;
    int e = 0;
    int bad = 0;
    logic xfer_pend;
    logic prev_active;
    logic [15:0] q[$];

    pwm_audio_sink_if bus();

    pwm_audio_sink #(.PWM_BITS(PWM_BITS), .REPEAT(REPEAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .audio    (bus),
        .pwm_out  (pwm_out),
        .underrun (underrun),
        .active   (active)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; equals the DUT's position in its period
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the source after a handshake, log output events
    task automatic tick();
        xfer_pend   = bus.audio_in_valid && bus.audio_in_rdy;
        prev_active = active;
        @(negedge clk);
        if (xfer_pend) begin
            if (q.size() > 0) bus.audio_in = q.pop_front();
            else              bus.audio_in_valid = 1'b0;
        end
        if (underrun) begin
            un_cnt++;
            un_n = n;
        end
        if (bus.audio_in_rdy) begin
            rdy_hi++;
            if (first_rdy < 0) first_rdy = n;
        end
        if (prev_active && !active && act_fall < 0) act_fall = n;
    endtask

    task automatic push(input logic [15:0] s);
        if (!bus.audio_in_valid) begin
            bus.audio_in       = s;
            bus.audio_in_valid = 1'b1;
        end else begin
            q.push_back(s);
        end
    endtask

    task automatic do_act(input int act);
        case (act)
            1: enable = 1'b0;
            2: enable = 1'b1;
            3: push(16'hC000);
            default: ;
        endcase
    endtask

    // High-time over one full PWM period equals that period's duty
    task automatic measure(input string tag, input int exp, input int act_cnt = -1, input int act = 0);
        int hi;
        int guard;
        hi = 0;
        guard = 0;
        do begin
            tick();
            guard++;
        end while ((n % PER) != 1 && guard < 40);
        for (int i = 0; i < PER; i++) begin
            if (i > 0) tick();
            hi += pwm_out ? 1 : 0;
            if ((n % PER) == act_cnt) do_act(act);
        end
        check(tag, 32'(hi), 32'(exp));
    endtask

    function automatic int s_at(input int k);
        return e + PER * (8 + k);
    endfunction

    initial begin
        int run_exp[15];
        int rev_exp[13];
        run_exp = '{8, 8, 0, 0, 8, 8, 15, 15, 12, 12, 12, 12, 4, 4, 15};
        rev_exp = '{0, 1, 2, 3, 4, 5, 4, 3, 4, 5, 6, 7, 8};
        bus.audio_in       = 16'h0000;
        bus.audio_in_valid = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_rdy", 32'(bus.audio_in_rdy), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;

        // Idle with enable low
        bad = 0;
        repeat (200) begin
            tick();
            if (pwm_out || bus.audio_in_rdy || active || underrun) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        measure("idle_duty", 0);

        // Ramp up from a frame-aligned point, source already holding samples
        do tick(); while ((n % (2 * PER)) != 0);
        push(16'h8000);
        push(16'h0000);
        push(16'h7FFF);
        push(16'h4000);
        first_rdy = -1;
        e = n;
        enable = 1'b1;
        for (int k = 0; k < 8; k++) measure($sformatf("ramp_duty%0d", k), k);
        check("first_rdy_cycle", 32'(first_rdy), 32'(s_at(0)));

        // RUN: back-to-back samples, then a starved frame with a late sample
        rdy_hi = 0;
        un_cnt = 0;
        un_n   = -1;
        for (int k = 0; k < 15; k++) begin
            if (k == 9)       measure($sformatf("run_p%0d", k), run_exp[k], 15, 3);
            else if (k == 14) measure($sformatf("run_p%0d", k), run_exp[k], 4, 1);
            else              measure($sformatf("run_p%0d", k), run_exp[k]);
            if (k == 6) check("rdy_pulses_full_buf", 32'(rdy_hi), 32'd3);
            if (k == 9) begin
                push(16'h7FFF);
                push(16'h0000);
            end
        end
        check("underrun_count", 32'(un_cnt), 32'd1);
        check("underrun_cycle", 32'(un_n), 32'(s_at(10)));
        check("rdy_after_disable", 32'(bus.audio_in_rdy), 32'd0);
        check("active_ramp_down", 32'(active), 32'd1);

        // Ramp down from 15 with the buffered sample discarded
        act_fall = -1;
        for (int k = 0; k < 15; k++) measure($sformatf("down_duty%0d", 14 - k), 14 - k);
        check("active_fall_cycle", 32'(act_fall), 32'(s_at(29) + 1));
        check("idle_active", 32'(active), 32'd0);

        // Ramp reversal: drop enable at duty 5, re-assert at duty 3
        do tick(); while ((n % PER) != 0);
        enable = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k == 5)      measure($sformatf("rev_p%0d", k), rev_exp[k], 4, 1);
            else if (k == 7) measure($sformatf("rev_p%0d", k), rev_exp[k], 4, 2);
            else             measure($sformatf("rev_p%0d", k), rev_exp[k]);
        end
        check("rev_run_rdy", 32'(bus.audio_in_rdy), 32'd1);
        check("rev_run_active", 32'(active), 32'd1);

        // Asynchronous reset in the middle of a high PWM phase
        do tick(); while ((n % PER) != 3);
        check("pre_rst_pwm", 32'(pwm_out), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_rdy", 32'(bus.audio_in_rdy), 32'd0);
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_underrun", 32'(underrun), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) tick();
        check("post_rst_active", 32'(active), 32'd0);
        check("post_rst_pwm", 32'(pwm_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
